// File: rtl/id_ex_if.sv
// Decode/execute boundary bundle: ID_* fields in, registered EX_* fields and stall controls out.
interface id_ex_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
);
    logic              ID_RegWrite;
    logic              ID_MemtoReg;
    logic              ID_MemRead;
    logic              ID_MemWrite;
    logic              ID_ALUSrc;
    logic              ID_RegDst;
    logic [1:0]        ID_ALUOp;
    logic [DATA_W-1:0] ID_ReadData1;
    logic [DATA_W-1:0] ID_ReadData2;
    logic [DATA_W-1:0] ID_Imm;
    logic [DATA_W-1:0] ID_PC4;
    logic [4:0]        ID_Rs;
    logic [4:0]        ID_Rt;
    logic [4:0]        ID_Rd;
    logic              ID_UsesRt;
    logic              Flush;

    logic              EX_RegWrite;
    logic              EX_MemtoReg;
    logic              EX_MemRead;
    logic              EX_MemWrite;
    logic              EX_ALUSrc;
    logic              EX_RegDst;
    logic [1:0]        EX_ALUOp;
    logic [DATA_W-1:0] EX_ReadData1;
    logic [DATA_W-1:0] EX_ReadData2;
    logic [DATA_W-1:0] EX_Imm;
    logic [DATA_W-1:0] EX_PC4;
    logic [4:0]        EX_Rs;
    logic [4:0]        EX_Rt;
    logic [4:0]        EX_Rd;
    logic              EX_Valid;
    logic              PCWrite;
    logic              IF_ID_Write;
    logic [CNT_W-1:0]  BubbleCount;

    // Decode side: drives the ID_* fields and observes the registered stage.
    modport master (
        output ID_RegWrite, ID_MemtoReg, ID_MemRead, ID_MemWrite, ID_ALUSrc, ID_RegDst,
        output ID_ALUOp, ID_ReadData1, ID_ReadData2, ID_Imm, ID_PC4,
        output ID_Rs, ID_Rt, ID_Rd, ID_UsesRt, Flush,
        input  EX_RegWrite, EX_MemtoReg, EX_MemRead, EX_MemWrite, EX_ALUSrc, EX_RegDst,
        input  EX_ALUOp, EX_ReadData1, EX_ReadData2, EX_Imm, EX_PC4,
        input  EX_Rs, EX_Rt, EX_Rd, EX_Valid, PCWrite, IF_ID_Write, BubbleCount
    );

    // Pipeline register side.
    modport slave (
        input  ID_RegWrite, ID_MemtoReg, ID_MemRead, ID_MemWrite, ID_ALUSrc, ID_RegDst,
        input  ID_ALUOp, ID_ReadData1, ID_ReadData2, ID_Imm, ID_PC4,
        input  ID_Rs, ID_Rt, ID_Rd, ID_UsesRt, Flush,
        output EX_RegWrite, EX_MemtoReg, EX_MemRead, EX_MemWrite, EX_ALUSrc, EX_RegDst,
        output EX_ALUOp, EX_ReadData1, EX_ReadData2, EX_Imm, EX_PC4,
        output EX_Rs, EX_Rt, EX_Rd, EX_Valid, PCWrite, IF_ID_Write, BubbleCount
    );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection, bubble injection and a
// saturating bubble counter.
module id_ex_stage_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input logic   clk,
    input logic   rst_n,
    id_ex_if.slave bus
);

    typedef struct packed {
        logic       regWrite;
        logic       memtoReg;
        logic       memRead;
        logic       memWrite;
        logic       aluSrc;
        logic       regDst;
        logic [1:0] aluOp;
    } ctrl_t;

    ctrl_t             ctrlQ, ctrlD;
    logic              validQ, validD;
    logic [4:0]        rsQ, rsD;
    logic [4:0]        rtQ, rtD;
    logic [4:0]        rdQ, rdD;
    logic [DATA_W-1:0] rd1Q, rd2Q, immQ, pc4Q;
    logic [CNT_W-1:0]  cntQ, cntD;

    logic stall;
    logic loadBubble;
    logic rtMatch;

    // Hazard is evaluated against the instruction already latched in EX, never a bubble.
    always_comb begin
        rtMatch = bus.ID_UsesRt && (rtQ == bus.ID_Rt);
        stall   = validQ && ctrlQ.memRead && (rtQ != 5'd0) && ((rtQ == bus.ID_Rs) || rtMatch);
    end

    assign loadBubble      = bus.Flush || stall;
    assign bus.PCWrite     = ~stall;
    assign bus.IF_ID_Write = ~stall;

    always_comb begin
        ctrlD.regWrite = bus.ID_RegWrite;
        ctrlD.memtoReg = bus.ID_MemtoReg;
        ctrlD.memRead  = bus.ID_MemRead;
        ctrlD.memWrite = bus.ID_MemWrite;
        ctrlD.aluSrc   = bus.ID_ALUSrc;
        ctrlD.regDst   = bus.ID_RegDst;
        ctrlD.aluOp    = bus.ID_ALUOp;
        validD         = 1'b1;
        rsD            = bus.ID_Rs;
        rtD            = bus.ID_Rt;
        rdD            = bus.ID_Rd;
        if (loadBubble) begin
            // Zeroed specifiers keep a bubble from matching any forwarding compare.
            ctrlD  = '0;
            validD = 1'b0;
            rsD    = 5'd0;
            rtD    = 5'd0;
            rdD    = 5'd0;
        end
    end

    always_comb begin
        cntD = cntQ;
        if (loadBubble && !(&cntQ)) begin
            cntD = cntQ + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrlQ  <= '0;
            validQ <= 1'b0;
            rsQ    <= 5'd0;
            rtQ    <= 5'd0;
            rdQ    <= 5'd0;
            rd1Q   <= '0;
            rd2Q   <= '0;
            immQ   <= '0;
            pc4Q   <= '0;
            cntQ   <= '0;
        end else begin
            ctrlQ  <= ctrlD;
            validQ <= validD;
            rsQ    <= rsD;
            rtQ    <= rtD;
            rdQ    <= rdD;
            rd1Q   <= bus.ID_ReadData1;
            rd2Q   <= bus.ID_ReadData2;
            immQ   <= bus.ID_Imm;
            pc4Q   <= bus.ID_PC4;
            cntQ   <= cntD;
        end
    end

    assign bus.EX_RegWrite  = ctrlQ.regWrite;
    assign bus.EX_MemtoReg  = ctrlQ.memtoReg;
    assign bus.EX_MemRead   = ctrlQ.memRead;
    assign bus.EX_MemWrite  = ctrlQ.memWrite;
    assign bus.EX_ALUSrc    = ctrlQ.aluSrc;
    assign bus.EX_RegDst    = ctrlQ.regDst;
    assign bus.EX_ALUOp     = ctrlQ.aluOp;
    assign bus.EX_Valid     = validQ;
    assign bus.EX_Rs        = rsQ;
    assign bus.EX_Rt        = rtQ;
    assign bus.EX_Rd        = rdQ;
    assign bus.EX_ReadData1 = rd1Q;
    assign bus.EX_ReadData2 = rd2Q;
    assign bus.EX_Imm       = immQ;
    assign bus.EX_PC4       = pc4Q;
    assign bus.BubbleCount  = cntQ;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg: stimulus queues expected values, monitors pop and compare.
module tb_id_ex_stage_reg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;

    // ctrl packs {RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, RegDst, ALUOp[1:0]}
    typedef struct packed {
        logic [7:0]        ctrl;
        logic              valid;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        rd;
        logic              chkData;
        logic [DATA_W-1:0] rd1;
        logic [CNT_W-1:0]  cnt;
    } exp_t;

    typedef struct packed {
        logic chk;
        logic pcw;
    } comb_t;

    localparam logic [7:0] CtrlLw   = 8'b1110_1000;
    localparam logic [7:0] CtrlRtyp = 8'b1000_0110;
    localparam logic [7:0] CtrlAddi = 8'b1000_1000;
    localparam logic [7:0] CtrlSw   = 8'b0001_1000;

    logic clk;
    logic rst_n;
    int   nChecks;
    int   nFail;

    exp_t  regQ[$];
    comb_t combQ[$];

    id_ex_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    id_ex_stage_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, regQ=%0d combQ=%0d",
                 regQ.size(), combQ.size());
        $fatal(1, "watchdog");
    end

    // Combinational stall outputs, checked mid-cycle with the step's inputs applied.
    always @(negedge clk) begin
        comb_t c;
        if (combQ.size() > 0) begin
            c = combQ.pop_front();
            if (c.chk) begin
                nChecks++;
                if (bus.PCWrite !== c.pcw || bus.IF_ID_Write !== c.pcw) begin
                    nFail++;
                    $display("FAIL stall_ctl @%0t: PCWrite=%b IF_ID_Write=%b required %b",
                             $time, bus.PCWrite, bus.IF_ID_Write, c.pcw);
                end
            end
        end
    end

    // Registered outputs, checked just after the edge that loaded them.
    always @(posedge clk) begin
        exp_t       e;
        logic [7:0] ctrl;
        logic       bad;
        #1;
        if (regQ.size() > 0) begin
            e    = regQ.pop_front();
            ctrl = {bus.EX_RegWrite, bus.EX_MemtoReg, bus.EX_MemRead, bus.EX_MemWrite,
                    bus.EX_ALUSrc, bus.EX_RegDst, bus.EX_ALUOp};
            bad  = (ctrl !== e.ctrl) || (bus.EX_Valid !== e.valid) || (bus.EX_Rs !== e.rs) ||
                   (bus.EX_Rt !== e.rt) || (bus.EX_Rd !== e.rd) || (bus.BubbleCount !== e.cnt);
            if (e.chkData) begin
                bad = bad || (bus.EX_ReadData1 !== e.rd1) || (bus.EX_PC4 !== e.rd1 + 32'd4);
            end
            nChecks++;
            if (bad) begin
                nFail++;
                $display({"FAIL ex_regs @%0t: ctrl=%b valid=%b rs=%0d rt=%0d rd=%0d rd1=%h ",
                          "pc4=%h cnt=%0d required ctrl=%b valid=%b rs=%0d rt=%0d rd=%0d ",
                          "rd1=%h cnt=%0d"},
                         $time, ctrl, bus.EX_Valid, bus.EX_Rs, bus.EX_Rt, bus.EX_Rd,
                         bus.EX_ReadData1, bus.EX_PC4, bus.BubbleCount, e.ctrl, e.valid,
                         e.rs, e.rt, e.rd, e.rd1, e.cnt);
            end
        end
    end

    function automatic exp_t ins(input logic [7:0] ctrl, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic [4:0] rd,
                                 input logic [DATA_W-1:0] rd1, input logic [CNT_W-1:0] cnt);
        exp_t e;
        e.ctrl = ctrl; e.valid = 1'b1; e.rs = rs; e.rt = rt; e.rd = rd;
        e.chkData = 1'b1; e.rd1 = rd1; e.cnt = cnt;
        return e;
    endfunction

    function automatic exp_t bub(input logic [CNT_W-1:0] cnt);
        exp_t e;
        e = '0;
        e.cnt = cnt;
        return e;
    endfunction

    task automatic setId(input logic [7:0] ctrl, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic usesRt, input logic [DATA_W-1:0] rd1);
        {bus.ID_RegWrite, bus.ID_MemtoReg, bus.ID_MemRead, bus.ID_MemWrite,
         bus.ID_ALUSrc, bus.ID_RegDst, bus.ID_ALUOp} = ctrl;
        bus.ID_Rs        = rs;
        bus.ID_Rt        = rt;
        bus.ID_Rd        = rd;
        bus.ID_UsesRt    = usesRt;
        bus.ID_ReadData1 = rd1;
        bus.ID_ReadData2 = ~rd1;
        bus.ID_Imm       = rd1 ^ 32'h0000_FFFF;
        bus.ID_PC4       = rd1 + 32'd4;
    endtask

    // Inputs are already applied; queue expectations and advance one clock.
    task automatic step(input logic chkC, input logic pcw, input exp_t e);
        comb_t c;
        c.chk = chkC;
        c.pcw = pcw;
        combQ.push_back(c);
        regQ.push_back(e);
        @(posedge clk);
        #2;
    endtask

    initial begin
        nChecks = 0;
        nFail   = 0;
        rst_n   = 1'b0;
        bus.Flush = 1'b0;
        setId(8'hFF, 5'd31, 5'd31, 5'd31, 1'b1, 32'hFFFF_FFFF);

        // Reset with every ID field high.
        step(1'b0, 1'b1, bub(4'd0));
        step(1'b1, 1'b1, bub(4'd0));
        rst_n = 1'b1;

        // Pass-through.
        setId(8'b1000_0010, 5'd3, 5'd4, 5'd5, 1'b1, 32'h0000_1234);
        step(1'b1, 1'b1, ins(8'b1000_0010, 5'd3, 5'd4, 5'd5, 32'h0000_1234, 4'd0));

        // Load-use on Rs: lw $8, then add reading $8.
        setId(CtrlLw, 5'd1, 5'd8, 5'd0, 1'b0, 32'h0000_0100);
        step(1'b1, 1'b1, ins(CtrlLw, 5'd1, 5'd8, 5'd0, 32'h0000_0100, 4'd0));
        setId(CtrlRtyp, 5'd8, 5'd9, 5'd10, 1'b1, 32'h0000_AAAA);
        step(1'b1, 1'b0, bub(4'd1));
        step(1'b1, 1'b1, ins(CtrlRtyp, 5'd8, 5'd9, 5'd10, 32'h0000_AAAA, 4'd1));

        // Load to $zero never stalls.
        setId(CtrlLw, 5'd2, 5'd0, 5'd0, 1'b0, 32'h0000_0200);
        step(1'b1, 1'b1, ins(CtrlLw, 5'd2, 5'd0, 5'd0, 32'h0000_0200, 4'd1));
        setId(CtrlRtyp, 5'd0, 5'd0, 5'd3, 1'b1, 32'h0000_0300);
        step(1'b1, 1'b1, ins(CtrlRtyp, 5'd0, 5'd0, 5'd3, 32'h0000_0300, 4'd1));

        // Rt match ignored when decode does not read Rt.
        setId(CtrlLw, 5'd1, 5'd6, 5'd0, 1'b0, 32'h0000_0400);
        step(1'b1, 1'b1, ins(CtrlLw, 5'd1, 5'd6, 5'd0, 32'h0000_0400, 4'd1));
        setId(CtrlAddi, 5'd7, 5'd6, 5'd0, 1'b0, 32'h0000_0500);
        step(1'b1, 1'b1, ins(CtrlAddi, 5'd7, 5'd6, 5'd0, 32'h0000_0500, 4'd1));

        // Rt match stalls when decode reads Rt (store data).
        setId(CtrlLw, 5'd1, 5'd6, 5'd0, 1'b0, 32'h0000_0600);
        step(1'b1, 1'b1, ins(CtrlLw, 5'd1, 5'd6, 5'd0, 32'h0000_0600, 4'd1));
        setId(CtrlSw, 5'd7, 5'd6, 5'd0, 1'b1, 32'h0000_0700);
        step(1'b1, 1'b0, bub(4'd2));
        step(1'b1, 1'b1, ins(CtrlSw, 5'd7, 5'd6, 5'd0, 32'h0000_0700, 4'd2));

        // Flush coincident with a load-use hazard: one bubble, one increment.
        setId(CtrlLw, 5'd1, 5'd8, 5'd0, 1'b0, 32'h0000_0800);
        step(1'b1, 1'b1, ins(CtrlLw, 5'd1, 5'd8, 5'd0, 32'h0000_0800, 4'd2));
        setId(CtrlRtyp, 5'd8, 5'd2, 5'd4, 1'b1, 32'h0000_0900);
        bus.Flush = 1'b1;
        step(1'b1, 1'b0, bub(4'd3));
        bus.Flush = 1'b0;
        step(1'b1, 1'b1, ins(CtrlRtyp, 5'd8, 5'd2, 5'd4, 32'h0000_0900, 4'd3));

        // 20 flushes: counter climbs from 3 and pins at 15.
        bus.Flush = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step(1'b1, 1'b1, bub((3 + i > 15) ? 4'd15 : 4'(3 + i)));
        end
        bus.Flush = 1'b0;

        // Reset during a stall: next cycle the held instruction proceeds, counter cleared.
        setId(CtrlLw, 5'd1, 5'd8, 5'd0, 1'b0, 32'h0000_0A00);
        step(1'b1, 1'b1, ins(CtrlLw, 5'd1, 5'd8, 5'd0, 32'h0000_0A00, 4'd15));
        setId(CtrlRtyp, 5'd8, 5'd3, 5'd5, 1'b1, 32'h0000_0B00);
        rst_n = 1'b0;
        step(1'b1, 1'b0, bub(4'd0));
        rst_n = 1'b1;
        step(1'b1, 1'b1, ins(CtrlRtyp, 5'd8, 5'd3, 5'd5, 32'h0000_0B00, 4'd0));

        @(negedge clk);
        nChecks++;
        if (regQ.size() != 0 || combQ.size() != 0) begin
            nFail++;
            $display("FAIL drain: regQ=%0d combQ=%0d entries left, required 0",
                     regQ.size(), combQ.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register for the 5-stage MIPS core.
- Sits between decode and execute. Its registered EX_Rs/EX_Rt feed the forwarding unit's Rs/Rt inputs. Its registered control bits feed EX and travel on toward EX/MEM.
- Contains the load-use hazard detector. On a load-use hazard it stalls PC and IF/ID and injects a bubble into EX.
- Counts injected bubbles for performance monitoring.

Parameters:
- DATA_W, 32, width of register-file data, immediate and PC+4 fields.
- CNT_W, 16, width of the saturating bubble counter.

Ports:
- clk  input  1  pipeline clock, all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- ID_RegWrite, ID_MemtoReg, ID_MemRead, ID_MemWrite, ID_ALUSrc, ID_RegDst  input  1 each  decoded control bits.
- ID_ALUOp  input  2  decoded ALU operation class.
- ID_ReadData1, ID_ReadData2  input  DATA_W  register-file read data.
- ID_Imm  input  DATA_W  sign-extended immediate.
- ID_PC4  input  DATA_W  PC+4 of the decode instruction.
- ID_Rs, ID_Rt, ID_Rd  input  5 each  decode register specifiers.
- ID_UsesRt  input  1  decode instruction reads Rt as a source (R-type, store, branch).
- Flush  input  1  branch/jump taken; squash the instruction currently in decode.
- EX_RegWrite, EX_MemtoReg, EX_MemRead, EX_MemWrite, EX_ALUSrc, EX_RegDst  output  1 each  registered control.
- EX_ALUOp  output  2  registered ALU op.
- EX_ReadData1, EX_ReadData2, EX_Imm, EX_PC4  output  DATA_W  registered data.
- EX_Rs, EX_Rt, EX_Rd  output  5 each  registered specifiers; EX_Rs/EX_Rt go to the forwarding unit.
- EX_Valid  output  1  EX slot holds a real instruction, not a bubble.
- PCWrite  output  1  combinational; 0 freezes the PC.
- IF_ID_Write  output  1  combinational; 0 freezes the IF/ID register.
- BubbleCount  output  CNT_W  saturating count of injected bubbles.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - All registered outputs go to 0, including EX_Valid and BubbleCount.
  - PCWrite and IF_ID_Write read 1 after reset, because EX_MemRead=0.
  - Reset mid-stall clears the stall on the following cycle.
- Hazard detect (combinational, from current EX_* state and ID_* inputs):
  - Stall = EX_Valid & EX_MemRead & (EX_Rt != 0) & ((EX_Rt == ID_Rs) | (ID_UsesRt & (EX_Rt == ID_Rt))).
  - PCWrite = IF_ID_Write = ~Stall.
  - Flush does not affect PCWrite or IF_ID_Write; the fetch stage redirects itself.
- Register update each rising edge with rst_n=1, in priority order:
  1. Flush=1: load a bubble.
  2. Stall=1: load a bubble.
  3. Otherwise: load all ID_* fields and set EX_Valid=1.
- Bubble definition:
  - Control outputs are zeroed: RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, RegDst, ALUOp.
  - EX_Valid=0.
  - EX_Rs, EX_Rt, EX_Rd are zeroed, so a bubble never matches a forwarding comparison.
  - Data fields (ReadData1/2, Imm, PC4) are loaded from ID_* anyway; they are don't-care.
- Latency: one cycle from ID_* to EX_*. No combinational path from ID_* to EX_* outputs.
- Stall duration: exactly one cycle per load-use hazard. After the bubble, EX_MemRead=0, so Stall drops and the held decode instruction enters EX on the next edge.
- Flush and Stall together: Flush wins, a single bubble is loaded, and BubbleCount increments once.
- BubbleCount:
  - Increments by 1 on every edge that loads a bubble due to Stall or Flush.
  - Saturates at 2^CNT_W-1 with no wrap.
  - Cleared only by reset.
- $zero: a load targeting register 0 never stalls.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with all ID_* inputs at 1 -> all EX_* outputs = 0, EX_Valid=0, BubbleCount=0, PCWrite=1, IF_ID_Write=1.
- Pass-through: ID_RegWrite=1, ID_ALUOp=2'b10, ID_Rs=3, ID_Rt=4, ID_Rd=5, ID_ReadData1=32'h1234, no hazard -> the next cycle shows EX_RegWrite=1, EX_ALUOp=2'b10, EX_Rs=3, EX_Rt=4, EX_Rd=5, EX_ReadData1=32'h1234, EX_Valid=1.
- Load-use:
  - Stimulus: lw with Rt=8 in EX (EX_MemRead=1), decode add with Rs=8.
  - Required: Stall cycle has PCWrite=0 and IF_ID_Write=0.
  - Required: the next EX has all controls 0, EX_Valid=0, BubbleCount=1.
  - Required: the following cycle has the add in EX with EX_Rs=8, and PCWrite=1.
- Rt rules:
  - lw Rt=0 in EX with decode Rs=0 -> no stall.
  - lw Rt=6 with decode Rt=6 and ID_UsesRt=0 -> no stall.
  - lw Rt=6 with decode Rt=6 and ID_UsesRt=1 -> stall.
- Flush and stall together: assert Flush in the same cycle as a load-use hazard -> one bubble loaded, BubbleCount increments by 1 only.
- Saturation: with CNT_W=4, apply 20 flushes -> BubbleCount stops at 15.
